ccastles_trackball_decoder: RTL and testbench

Quadrature trackball receiver for the Crystal Castles core. It takes the horizontal and vertical A/B phase pairs from the trackball, or from the bench stimulus that generates them, and synchronizes and deglitches them. It decodes them into two wrapping 8-bit position counters that the CPU reads through a one-byte read port. The block sits between the MiSTer input layer (or testbench quadrature generator) and the CPU input-port decode inside `CCastles`.

---
 rtl/ccastles_trackball_decoder.sv | 169 ++++++++++++++++
 tb/tb_ccastles_trackball_decoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccastles_trackball_decoder.sv
// Quadrature trackball receiver: synchronizes and deglitches four phase inputs,
// decodes two wrapping position counters and serves them over a one-byte read port.
module ccastles_trackball_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tb1HA,
    input  logic                 tb1HB,
    input  logic                 tb1VA,
    input  logic                 tb1VB,
    input  logic                 COCKTAIL,
    input  logic                 clr,
    input  logic                 rd,
    input  logic                 addr,
    output logic [CNT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 err_h,
    output logic                 err_v
);

    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

    localparam logic [1:0] STEP_NONE    = 2'b00;
    localparam logic [1:0] STEP_UP      = 2'b01;
    localparam logic [1:0] STEP_DOWN    = 2'b10;
    localparam logic [1:0] STEP_ILLEGAL = 2'b11;

    // Position of an {A,B} state along the forward cycle 00->10->11->01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        logic [1:0] idx;
        case (ab)
            2'b00:   idx = 2'd0;
            2'b10:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            2'b01:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] step_code(input logic [1:0] prev, input logic [1:0] cur,
                                             input logic cocktail);
        logic [1:0] delta;
        logic [1:0] code;
        delta = gray_idx(cur) - gray_idx(prev);
        case (delta)
            2'd0:    code = STEP_NONE;
            2'd1:    code = cocktail ? STEP_DOWN : STEP_UP;
            2'd3:    code = cocktail ? STEP_UP : STEP_DOWN;
            default: code = STEP_ILLEGAL;
        endcase
        return code;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] apply_step(input logic [CNT_WIDTH-1:0] cnt,
                                                        input logic [1:0] code);
        logic [CNT_WIDTH-1:0] res;
        case (code)
            STEP_UP:   res = cnt + CNT_WIDTH'(1);
            STEP_DOWN: res = cnt - CNT_WIDTH'(1);
            default:   res = cnt;
        endcase
        return res;
    endfunction

    // Bit order: 0 = HA, 1 = HB, 2 = VA, 3 = VB.
    logic [3:0]             phase_s;
    logic [SYNC_STAGES-1:0] sync_r [4];
    logic [3:0]             stab_r [4];
    logic [3:0]             filt_r;
    logic [1:0]             prev_h_r, prev_v_r;
    logic [1:0]             cur_h_s, cur_v_s;
    logic [1:0]             step_h_s, step_v_s;
    logic [CNT_WIDTH-1:0]   cnt_h_r, cnt_v_r;
    logic [CNT_WIDTH-1:0]   dout_r;
    logic                   dout_valid_r;
    logic                   err_h_r, err_v_r;

    assign phase_s = {tb1VB, tb1VA, tb1HB, tb1HA};

    // Metastability synchronizer chain per phase input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) sync_r[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], phase_s[i]};
        end
    end

    // Stability filter: accept a new level only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_r <= 4'b0000;
            for (int i = 0; i < 4; i++) stab_r[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_r[i][SYNC_STAGES-1] != filt_r[i]) begin
                    if (stab_r[i] == FILT_LAST) begin
                        filt_r[i] <= sync_r[i][SYNC_STAGES-1];
                        stab_r[i] <= 4'd0;
                    end else begin
                        stab_r[i] <= stab_r[i] + 4'd1;
                    end
                end else begin
                    stab_r[i] <= 4'd0;
                end
            end
        end
    end

    // Step decode from previous versus current filtered state on each axis.
    always_comb begin
        cur_h_s  = {filt_r[0], filt_r[1]};
        cur_v_s  = {filt_r[2], filt_r[3]};
        step_h_s = step_code(prev_h_r, cur_h_s, COCKTAIL);
        step_v_s = step_code(prev_v_r, cur_v_s, COCKTAIL);
    end

    // Position counters and sticky error flags; clr wins over any step in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_h_r <= 2'b00;
            prev_v_r <= 2'b00;
            cnt_h_r  <= '0;
            cnt_v_r  <= '0;
            err_h_r  <= 1'b0;
            err_v_r  <= 1'b0;
        end else begin
            prev_h_r <= cur_h_s;
            prev_v_r <= cur_v_s;
            if (clr) begin
                cnt_h_r <= '0;
                cnt_v_r <= '0;
                err_h_r <= 1'b0;
                err_v_r <= 1'b0;
            end else begin
                cnt_h_r <= apply_step(cnt_h_r, step_h_s);
                cnt_v_r <= apply_step(cnt_v_r, step_v_s);
                err_h_r <= err_h_r | (step_h_s == STEP_ILLEGAL);
                err_v_r <= err_v_r | (step_v_s == STEP_ILLEGAL);
            end
        end
    end

    // CPU read port returns the counter value held before this cycle's update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            if (rd) begin
                dout_r       <= addr ? cnt_v_r : cnt_h_r;
                dout_valid_r <= 1'b1;
            end else begin
                dout_valid_r <= 1'b0;
            end
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign err_h      = err_h_r;
    assign err_v      = err_v_r;

endmodule

// File: tb/tb_ccastles_trackball_decoder.sv
// Directed testbench for ccastles_trackball_decoder with hand-computed expectations.
module tb_ccastles_trackball_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tb1HA = 1'b0, tb1HB = 1'b0, tb1VA = 1'b0, tb1VB = 1'b0;
    logic       COCKTAIL = 1'b0;
    logic       clr = 1'b0;
    logic       rd = 1'b0;
    logic       addr = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       err_h, err_v;

    int tests_run = 0;
    int tests_failed = 0;

    ccastles_trackball_decoder #(.SYNC_STAGES(2), .FILTER_LEN(3), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .tb1HA(tb1HA), .tb1HB(tb1HB), .tb1VA(tb1VA), .tb1VB(tb1VB),
        .COCKTAIL(COCKTAIL), .clr(clr), .rd(rd), .addr(addr),
        .dout(dout), .dout_valid(dout_valid), .err_h(err_h), .err_v(err_v)
    );

    always #50 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {tb1HA, tb1HB, tb1VA, tb1VB} = 4'b0000;
        COCKTAIL = 1'b0; clr = 1'b0; rd = 1'b0; addr = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic do_read(input logic a, output logic [7:0] d, output logic v);
        rd = 1'b1;
        addr = a;
        tick(1);
        d = dout;
        v = dout_valid;
        rd = 1'b0;
    endtask

    task automatic step_h(input logic a, input logic b);
        tb1HA = a; tb1HB = b;
        tick(10);
    endtask

    task automatic test_reset();
        logic [7:0] d; logic v;
        reset_n = 1'b0;
        tick(2);
        tests_run++;
        if ({dout, dout_valid, err_h, err_v} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got dout=%h valid=%b err_h=%b err_v=%b, want all 0", dout, dout_valid, err_h, err_v);
        end
        reset_n = 1'b1;
        tick(1);
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'h00 || v !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_cnt_h: got %h valid=%b, want 00 valid=1", d, v);
        end
    endtask

    task automatic test_forward();
        logic [7:0] d; logic v;
        do_reset();
        step_h(1'b1, 1'b0);
        step_h(1'b1, 1'b1);
        step_h(1'b0, 1'b1);
        step_h(1'b0, 1'b0);
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'h04 || err_h !== 1'b0) begin
            tests_failed++;
            $display("FAIL forward_h: got %h err_h=%b, want 04 err_h=0", d, err_h);
        end
        do_read(1'b1, d, v);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("FAIL forward_v_idle: got %h, want 00", d);
        end
    endtask

    task automatic test_back_to_back();
        rd = 1'b1; addr = 1'b0;
        tick(1);
        tests_run++;
        if (dout !== 8'h04 || dout_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h valid=%b, want 04 valid=1", dout, dout_valid);
        end
        addr = 1'b1;
        tick(1);
        tests_run++;
        if (dout !== 8'h00 || dout_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h valid=%b, want 00 valid=1", dout, dout_valid);
        end
        rd = 1'b0;
        tick(1);
        tests_run++;
        if (dout !== 8'h00 || dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: got %h valid=%b, want 00 valid=0", dout, dout_valid);
        end
    endtask

    task automatic test_reverse_wrap();
        logic [7:0] d; logic v;
        do_reset();
        step_h(1'b0, 1'b1);
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reverse_wrap: got %h, want ff", d);
        end
        step_h(1'b0, 1'b0);
        step_h(1'b1, 1'b0);
        step_h(1'b1, 1'b1);
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'h02 || err_h !== 1'b0) begin
            tests_failed++;
            $display("FAIL forward_wrap: got %h err_h=%b, want 02 err_h=0", d, err_h);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] d; logic v;
        do_reset();
        tb1HA = 1'b1;
        tick(2);
        tb1HA = 1'b0;
        tick(10);
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("FAIL glitch_2cyc: got %h, want 00", d);
        end
        // 3-cycle pulse: first sampling edge is P1; counter must change at P6.
        tb1HA = 1'b1;
        tick(3);
        tb1HA = 1'b0;
        tick(2);
        rd = 1'b1; addr = 1'b0;
        tick(1);
        tests_run++;
        if (dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL glitch_latency_early: got %h at edge 6 read, want 00", dout);
        end
        tick(1);
        tests_run++;
        if (dout !== 8'h01 || dout_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_latency_hit: got %h valid=%b, want 01 valid=1", dout, dout_valid);
        end
        rd = 1'b0;
        tick(10);
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'h00 || err_h !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_return: got %h err_h=%b, want 00 err_h=0", d, err_h);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] d; logic v;
        do_reset();
        tb1VA = 1'b1; tb1VB = 1'b1;
        tick(10);
        do_read(1'b1, d, v);
        tests_run++;
        if (d !== 8'h00 || err_v !== 1'b1 || err_h !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_v: got %h err_v=%b err_h=%b, want 00 1 0", d, err_v, err_h);
        end
        tick(10);
        do_read(1'b1, d, v);
        tests_run++;
        if (err_v !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_sticky: got err_v=%b, want 1", err_v);
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tests_run++;
        if (err_v !== 1'b0 || err_h !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_clr: got err_v=%b err_h=%b, want 0 0", err_v, err_h);
        end
    endtask

    task automatic test_cocktail();
        logic [7:0] d; logic v;
        do_reset();
        COCKTAIL = 1'b1;
        step_h(1'b1, 1'b0);
        step_h(1'b1, 1'b1);
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'hFE) begin
            tests_failed++;
            $display("FAIL cocktail_dir: got %h, want fe", d);
        end
        // Step 11->01 lands at the 6th edge; clr sampled on that same edge.
        tb1HA = 1'b0;
        tick(5);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("FAIL cocktail_clr_step: got %h, want 00", d);
        end
        tick(10);
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'h00 || err_h !== 1'b0) begin
            tests_failed++;
            $display("FAIL cocktail_step_lost: got %h err_h=%b, want 00 0", d, err_h);
        end
        COCKTAIL = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] d; logic v;
        do_reset();
        step_h(1'b1, 1'b0);
        tb1VA = 1'b1; tb1VB = 1'b1;
        tick(10);
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'h01 || err_v !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre: got %h err_v=%b, want 01 1", d, err_v);
        end
        tb1HB = 1'b1;
        tick(3);
        #20;
        reset_n = 1'b0;
        {tb1HA, tb1HB, tb1VA, tb1VB} = 4'b0000;
        #5;
        tests_run++;
        if ({dout, dout_valid, err_h, err_v} !== 11'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got dout=%h valid=%b err_h=%b err_v=%b, want all 0", dout, dout_valid, err_h, err_v);
        end
        tick(2);
        #20;
        reset_n = 1'b1;
        tick(1);
        step_h(1'b1, 1'b0);
        do_read(1'b0, d, v);
        tests_run++;
        if (d !== 8'h01 || err_h !== 1'b0 || err_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_post: got %h err_h=%b err_v=%b, want 01 0 0", d, err_h, err_v);
        end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_forward();
        test_back_to_back();
        test_reverse_wrap();
        test_glitch();
        test_illegal();
        test_cocktail();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
